// File: rtl/ctr_pkg.sv
// Shared defaults and wrap-mode encoding for the parameterised saturating counter.
package ctr_pkg;

   localparam int unsigned CTR_WIDTH_DEF = 3;
   localparam int unsigned CTR_MAX_DEF   = 5;

   typedef enum logic {
      CTR_SAT  = 1'b0,
      CTR_WRAP = 1'b1
   } wrap_mode_e;

endpackage

// File: rtl/ctr_next.sv
// Next-state logic for the counter: priority ctr_rst > load > en > hold.
module ctr_next
   import ctr_pkg::*;
#(
   parameter int unsigned WIDTH = CTR_WIDTH_DEF,
   parameter int unsigned MAX   = CTR_MAX_DEF,
   parameter bit          WRAP  = CTR_SAT
) (
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             err_i,
   input  logic             ctr_rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             ovf_o,
   output logic             err_o
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
   localparam wrap_mode_e       MODE  = wrap_mode_e'(WRAP);

   // Bounds are tested by equality before stepping, so MAX = 2^WIDTH-1 never carries out.
   always_comb begin
      cnt_o = cnt_i;
      ovf_o = 1'b0;
      err_o = err_i;
      if (ctr_rst_i) begin
         cnt_o = '0;
         err_o = 1'b0;
      end else if (load_i) begin
         if (load_val_i > MAX_W) begin
            err_o = 1'b1;
         end else begin
            cnt_o = load_val_i;
         end
      end else if (en_i) begin
         if (up_i) begin
            if (cnt_i == MAX_W) begin
               ovf_o = 1'b1;
               cnt_o = (MODE == CTR_WRAP) ? '0 : MAX_W;
            end else begin
               cnt_o = cnt_i + WIDTH'(1);
            end
         end else begin
            if (cnt_i == '0) begin
               ovf_o = 1'b1;
               cnt_o = (MODE == CTR_WRAP) ? MAX_W : '0;
            end else begin
               cnt_o = cnt_i - WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/dff.sv
// Single-bit register cell with asynchronous active-high clear.
module dff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/param_sat_ctr.sv
// Parameterised up/down counter with load, saturate-or-wrap bounds, overflow pulse and sticky load error.
module param_sat_ctr
   import ctr_pkg::*;
#(
   parameter int unsigned WIDTH = CTR_WIDTH_DEF,
   parameter int unsigned MAX   = CTR_MAX_DEF,
   parameter bit          WRAP  = CTR_SAT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctr_rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             at_max,
   output logic             at_zero,
   output logic             ovf,
   output logic             err
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   ctr_next #(
      .WIDTH (WIDTH),
      .MAX   (MAX),
      .WRAP  (WRAP)
   ) u_next (
      .cnt_i      (cnt_q),
      .err_i      (err_q),
      .ctr_rst_i  (ctr_rst),
      .load_i     (load),
      .load_val_i (load_val),
      .en_i       (en),
      .up_i       (up),
      .cnt_o      (cnt_d),
      .ovf_o      (ovf_d),
      .err_o      (err_d)
   );

   for (genvar b = 0; b < WIDTH; b++) begin : g_cnt
      dff u_dff (
         .clk (clk),
         .rst (rst),
         .d   (cnt_d[b]),
         .q   (cnt_q[b])
      );
   end

   dff u_ovf (
      .clk (clk),
      .rst (rst),
      .d   (ovf_d),
      .q   (ovf_q)
   );

   dff u_err (
      .clk (clk),
      .rst (rst),
      .d   (err_d),
      .q   (err_q)
   );

   assign out     = cnt_q;
   assign ovf     = ovf_q;
   assign err     = err_q;
   assign at_max  = (cnt_q == MAX_W);
   assign at_zero = (cnt_q == '0);

endmodule

// File: tb/tb_param_sat_ctr.sv
// Bench for param_sat_ctr: four parameterisations driven in parallel against an integer reference model.
module tb_param_sat_ctr;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ctr_rst = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic [3:0] lv = 4'd0;

   logic [2:0] out_a, out_b, out_d;
   logic [3:0] out_c;
   logic       amax [4];
   logic       azero[4];
   logic       ovf_o[4];
   logic       err_o[4];
   logic [3:0] cnt_o[4];

   int checks = 0;
   int failures = 0;

   // Reference parameters: A default sat, B wrap, C 4-bit full-range wrap, D 3-bit full-range sat
   int P_W  [4] = '{3, 3, 4, 3};
   int P_MAX[4] = '{5, 5, 15, 7};
   bit P_WR [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

   int m_cnt[4];
   bit m_ovf[4];
   bit m_err[4];

   always #5 clk = ~clk;

   param_sat_ctr u_a (
      .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .en(en), .up(up), .load(load),
      .load_val(lv[2:0]), .out(out_a), .at_max(amax[0]), .at_zero(azero[0]),
      .ovf(ovf_o[0]), .err(err_o[0])
   );

   param_sat_ctr #(.WIDTH(3), .MAX(5), .WRAP(1'b1)) u_b (
      .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .en(en), .up(up), .load(load),
      .load_val(lv[2:0]), .out(out_b), .at_max(amax[1]), .at_zero(azero[1]),
      .ovf(ovf_o[1]), .err(err_o[1])
   );

   param_sat_ctr #(.WIDTH(4), .MAX(15), .WRAP(1'b1)) u_c (
      .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .en(en), .up(up), .load(load),
      .load_val(lv), .out(out_c), .at_max(amax[2]), .at_zero(azero[2]),
      .ovf(ovf_o[2]), .err(err_o[2])
   );

   param_sat_ctr #(.WIDTH(3), .MAX(7), .WRAP(1'b0)) u_d (
      .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .en(en), .up(up), .load(load),
      .load_val(lv[2:0]), .out(out_d), .at_max(amax[3]), .at_zero(azero[3]),
      .ovf(ovf_o[3]), .err(err_o[3])
   );

   assign cnt_o[0] = {1'b0, out_a};
   assign cnt_o[1] = {1'b0, out_b};
   assign cnt_o[2] = out_c;
   assign cnt_o[3] = {1'b0, out_d};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0;
         m_ovf[i] = 1'b0;
         m_err[i] = 1'b0;
      end
   endtask

   // Plain integer arithmetic on the stated rules; load value truncated to the instance width.
   task automatic model_step(input int i, input bit c_rst, input bit c_ld, input int c_lv,
                             input bit c_en, input bit c_up);
      int v;
      v = c_lv % (1 << P_W[i]);
      m_ovf[i] = 1'b0;
      if (c_rst) begin
         m_cnt[i] = 0;
         m_err[i] = 1'b0;
      end else if (c_ld) begin
         if (v > P_MAX[i]) m_err[i] = 1'b1;
         else m_cnt[i] = v;
      end else if (c_en) begin
         if (c_up) begin
            if (m_cnt[i] + 1 > P_MAX[i]) begin
               m_ovf[i] = 1'b1;
               m_cnt[i] = P_WR[i] ? 0 : P_MAX[i];
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end else begin
            if (m_cnt[i] - 1 < 0) begin
               m_ovf[i] = 1'b1;
               m_cnt[i] = P_WR[i] ? P_MAX[i] : 0;
            end else begin
               m_cnt[i] = m_cnt[i] - 1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("d%0d.out", i), int'(cnt_o[i]), m_cnt[i]);
         chk($sformatf("d%0d.ovf", i), int'(ovf_o[i]), int'(m_ovf[i]));
         chk($sformatf("d%0d.err", i), int'(err_o[i]), int'(m_err[i]));
         chk($sformatf("d%0d.at_max", i), int'(amax[i]), int'(m_cnt[i] == P_MAX[i]));
         chk($sformatf("d%0d.at_zero", i), int'(azero[i]), int'(m_cnt[i] == 0));
      end
   endtask

   task automatic cycle(input bit c_rst, input bit c_ld, input int c_lv, input bit c_en, input bit c_up);
      ctr_rst = c_rst;
      load    = c_ld;
      lv      = 4'(c_lv);
      en      = c_en;
      up      = c_up;
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_step(i, c_rst, c_ld, c_lv, c_en, c_up);
      #1;
      check_all();
   endtask

   // Assert rst between edges and check the clear is visible before the next edge.
   task automatic mid_reset(input bit with_ctr_rst);
      #2;
      rst = 1'b1;
      ctr_rst = with_ctr_rst;
      #1;
      model_reset();
      check_all();
      #2;
      rst = 1'b0;
   endtask

   typedef struct {
      bit crst;
      bit ld;
      int lv;
      bit en;
      bit up;
      int e_out;
      bit e_ovf;
      bit e_err;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // Expected values for the default instance (WIDTH=3, MAX=5, saturate)
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b1, 2, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b1, 3, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 6, 1'b1, 1'b1, 2, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 3, 1'b0, 1'b0, 3, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4, 1'b1, 1'b1, 4, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 3, 1'b1, 1'b1, 0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 7, 1'b0, 1'b1, 0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 5, 1'b0, 1'b0, 5, 1'b0, 1'b1});

      model_reset();
      #2;
      check_all();
      #10;
      rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         cycle(tbl[k].crst, tbl[k].ld, tbl[k].lv, tbl[k].en, tbl[k].up);
         chk($sformatf("tbl%0d.out", k), int'(out_a), tbl[k].e_out);
         chk($sformatf("tbl%0d.ovf", k), int'(ovf_o[0]), int'(tbl[k].e_ovf));
         chk($sformatf("tbl%0d.err", k), int'(err_o[0]), int'(tbl[k].e_err));
      end

      // Wrap-down from 0 on the WRAP=1 instance
      cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("wrapdn.out", int'(out_b), 5);
      chk("wrapdn.ovf", int'(ovf_o[1]), 1);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
      chk("wrapdn2.out", int'(out_b), 4);
      chk("wrapdn2.ovf", int'(ovf_o[1]), 0);

      // Async reset mid-count, then resume from zero
      cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
      chk("pre_rst.out", int'(out_a), 3);
      mid_reset(1'b0);
      chk("async_rst.out", int'(out_a), 0);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
      chk("post_rst.out", int'(out_a), 1);

      // Full-range counters at 2^WIDTH-1
      cycle(1'b0, 1'b1, 14, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
      chk("c15.out", int'(out_c), 15);
      chk("c15.ovf", int'(ovf_o[2]), 0);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
      chk("c0.out", int'(out_c), 0);
      chk("c0.ovf", int'(ovf_o[2]), 1);
      chk("c0.at_zero", int'(azero[2]), 1);
      cycle(1'b0, 1'b1, 7, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
      chk("d7.out", int'(out_d), 7);
      chk("d7.ovf", int'(ovf_o[3]), 1);

      // rst together with ctr_rst
      mid_reset(1'b1);
      cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 600; n++) begin
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
               int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 49) == 0) mid_reset($urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
